// File: rtl/prbs15_checker.sv
// ============================================================================
// prbs15_checker : self-synchronising PRBS15 (x^15 + x^14 + 1) word checker
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prbs15_checker #(
    parameter int WORDWIDTH    = 15,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNTWIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dis,
    input  logic                 din_valid,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_word,
    output logic [6:0]           err_bits,
    output logic [CNTWIDTH-1:0]  err_cnt
);

    localparam int C_SUMW = ((CNTWIDTH > 7) ? CNTWIDTH : 7) + 1;
    localparam logic [C_SUMW-1:0] C_CNT_MAX = C_SUMW'({CNTWIDTH{1'b1}});

    typedef enum logic [0:0] {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    state_t                state_q;
    logic [14:0]           hist_q;
    logic                  hist_ok_q;
    logic [7:0]            good_cnt_q;
    logic [7:0]            bad_cnt_q;
    logic                  locked_q;
    logic                  err_word_q;
    logic [6:0]            err_bits_q;
    logic [CNTWIDTH-1:0]   err_cnt_q;
    logic [CNTWIDTH-1:0]   err_cnt_d;

    logic [WORDWIDTH+14:0] w_stream;
    logic [WORDWIDTH-1:0]  w_err_vec;
    logic [6:0]            w_pop;
    logic [C_SUMW-1:0]     w_sum;
    logic                  w_take;
    logic                  w_cmp;
    logic                  w_stuck;
    logic                  w_errored;

    // Oldest history bit sits at index 0, so bit j predicts from stream[j] ^ stream[j+1].
    assign w_stream = {din, hist_q};

    always_comb begin
        w_err_vec = '0;
        w_pop     = '0;
        for (int j = 0; j < WORDWIDTH; j++) begin
            w_err_vec[j] = din[j] ^ w_stream[j] ^ w_stream[j+1];
            w_pop        = w_pop + 7'(w_err_vec[j]);
        end
    end

    assign w_take    = din_valid && !dis;
    assign w_cmp     = w_take && hist_ok_q;
    assign w_stuck   = (hist_q == '0) && (din == '0);
    assign w_errored = (w_pop != '0) || w_stuck;
    assign w_sum     = C_SUMW'(err_cnt_q) + C_SUMW'(w_pop);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (w_cmp && (state_q == S_LOCKED)) begin
            err_cnt_d = (w_sum > C_CNT_MAX) ? '1 : w_sum[CNTWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_UNLOCKED;
            hist_q     <= '0;
            hist_ok_q  <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b0;
            err_word_q <= 1'b0;
            err_bits_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_word_q <= 1'b0;
            if (w_take) begin
                hist_q    <= din[WORDWIDTH-1 -: 15];
                hist_ok_q <= 1'b1;
                if (!hist_ok_q) begin
                    err_bits_q <= '0;
                end else begin
                    err_word_q <= w_errored;
                    err_bits_q <= w_pop;
                    case (state_q)
                        S_UNLOCKED: begin
                            if (w_errored) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q == 8'(LOCK_COUNT - 1)) begin
                                state_q    <= S_LOCKED;
                                locked_q   <= 1'b1;
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + 8'd1;
                            end
                        end
                        S_LOCKED: begin
                            if (!w_errored) begin
                                bad_cnt_q <= '0;
                            end else if (bad_cnt_q == 8'(UNLOCK_COUNT - 1)) begin
                                state_q    <= S_UNLOCKED;
                                locked_q   <= 1'b0;
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                            end else begin
                                bad_cnt_q <= bad_cnt_q + 8'd1;
                            end
                        end
                        default: begin
                            state_q  <= S_UNLOCKED;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign locked   = locked_q;
    assign err_word = err_word_q;
    assign err_bits = err_bits_q;
    assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs15_checker.sv
// ============================================================================
// tb_prbs15_checker : scoreboard bench for prbs15_checker (15-bit words, 4-bit err_cnt)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prbs15_checker;

    localparam int WW = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          dis;
    logic          din_valid;
    logic [WW-1:0] din;
    logic          clr_err;
    logic          locked;
    logic          err_word;
    logic [6:0]    err_bits;
    logic [CW-1:0] err_cnt;

    typedef struct packed {
        logic          l;
        logic          ew;
        logic [6:0]    eb;
        logic [CW-1:0] ec;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_mon    = 0;
    logic [14:0] g = 15'h1E4C;

    prbs15_checker #(
        .WORDWIDTH   (WW),
        .LOCK_COUNT  (4),
        .UNLOCK_COUNT(4),
        .CNTWIDTH    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dis      (dis),
        .din_valid(din_valid),
        .din      (din),
        .clr_err  (clr_err),
        .locked   (locked),
        .err_word (err_word),
        .err_bits (err_bits),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference PRBS15 generator, LSB-first: r[n] = r[n-14] ^ r[n-15].
    function automatic logic [14:0] gen();
        logic [14:0] w;
        logic        b;
        w = '0;
        for (int j = 0; j < 15; j++) begin
            b    = g[1] ^ g[0];
            w[j] = b;
            g    = {b, g[14:1]};
        end
        return w;
    endfunction

    function automatic int sat(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    task automatic step(input logic v, input logic d, input logic [14:0] w, input logic clr,
                        input logic el, input logic ew, input int eb, input int ec);
        exp_t e;
        @(negedge clk);
        din_valid = v;
        dis       = d;
        din       = w;
        clr_err   = clr;
        e.l  = el;
        e.ew = ew;
        e.eb = 7'(eb);
        e.ec = CW'(ec);
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset     = 1'b1;
        din_valid = 1'b0;
        clr_err   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_mon++;
                chk($sformatf("w%0d.locked", n_mon), int'(locked), int'(e.l));
                chk($sformatf("w%0d.err_word", n_mon), int'(err_word), int'(e.ew));
                chk($sformatf("w%0d.err_bits", n_mon), int'(err_bits), int'(e.eb));
                chk($sformatf("w%0d.err_cnt", n_mon), int'(err_cnt), int'(e.ec));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int c;
        reset = 1'b1; dis = 1'b0; din_valid = 1'b0; din = '0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.locked", int'(locked), 0);
        chk("rst.err_word", int'(err_word), 0);
        chk("rst.err_bits", int'(err_bits), 0);
        chk("rst.err_cnt", int'(err_cnt), 0);
        reset = 1'b0;

        // Clean lock: history word, then 4 clean words, then locked clean run.
        step(1, 0, gen(), 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, gen(), 0, (i == 4), 0, 0, 0);
        for (int i = 0; i < 495; i++) step(1, 0, gen(), 0, 1, 0, 0, 0);
        step(0, 0, 15'h2AAA, 0, 1, 0, 0, 0);

        // Single flip of bit 0: 2 flags in word k, 1 in word k+1; err_bits holds on idle.
        step(1, 0, gen() ^ 15'h0001, 0, 1, 1, 2, 2);
        step(1, 0, gen(), 0, 1, 1, 1, 3);
        step(0, 0, 15'h1234, 0, 1, 0, 1, 3);
        step(1, 0, gen(), 0, 1, 0, 0, 3);
        // dis ignores a garbage word entirely.
        step(1, 1, 15'h7FFF, 0, 1, 0, 0, 3);
        step(1, 0, gen(), 0, 1, 0, 0, 3);

        // Saturation: clear, then 6 single flips (18 errors) into a 4-bit counter.
        step(1, 0, gen(), 1, 1, 0, 0, 0);
        c = 0;
        for (int i = 0; i < 6; i++) begin
            c = sat(c + 2);
            step(1, 0, gen() ^ 15'h0001, 0, 1, 1, 2, c);
            c = sat(c + 1);
            step(1, 0, gen(), 0, 1, 1, 1, c);
            step(1, 0, gen(), 0, 1, 0, 0, c);
        end
        // clr_err wins over a 2-bit error word in the same cycle.
        step(1, 0, gen() ^ 15'h0001, 1, 1, 1, 2, 0);
        step(1, 0, gen(), 0, 1, 1, 1, 1);
        step(1, 0, gen(), 0, 1, 0, 0, 1);

        // Loss of lock: 4 words with bit 7 flipped give 1 flag each; tail word gives 2.
        step(1, 0, gen(), 1, 1, 0, 0, 0);
        step(1, 0, gen() ^ 15'h0080, 0, 1, 1, 1, 1);
        step(1, 0, gen() ^ 15'h0080, 0, 1, 1, 1, 2);
        step(1, 0, gen() ^ 15'h0080, 0, 1, 1, 1, 3);
        step(1, 0, gen() ^ 15'h0080, 0, 0, 1, 1, 4);
        step(1, 0, gen(), 0, 0, 1, 2, 4);
        for (int i = 1; i <= 4; i++) step(1, 0, gen(), 0, (i == 4), 0, 0, 4);
        step(1, 0, gen(), 0, 1, 0, 0, 4);

        // Stuck-zero: all-zero input never locks, words 2..10 flagged with 0 bits.
        pulse_reset();
        step(1, 0, 15'h0000, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 10; i++) step(1, 0, 15'h0000, 0, 0, 1, 0, 0);

        // Gapped valid pattern 1,0,0: stream stays contiguous across gaps.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 0, gen(), 0, (i >= 4), 0, 0, 0);
            step(0, 0, 15'h5A5A, 0, (i >= 4), 0, 0, 0);
            step(0, 0, 15'h0F0F, 0, (i >= 4), 0, 0, 0);
        end

        // Mid-stream asynchronous reset while locked with nonzero outputs.
        step(1, 0, gen() ^ 15'h0001, 0, 1, 1, 2, 2);
        step(1, 0, gen(), 0, 1, 1, 1, 3);
        #3;
        din_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("arst.locked", int'(locked), 0);
        chk("arst.err_word", int'(err_word), 0);
        chk("arst.err_bits", int'(err_bits), 0);
        chk("arst.err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, gen(), 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, gen(), 0, (i == 4), 0, 0, 0);
        step(1, 0, gen(), 0, 1, 0, 0, 0);
        step(0, 0, 15'h0000, 0, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prbs15_checker.md
# prbs15_checker

Receive-side PRBS15 checker for the ETROC2 readout test-pattern path. It consumes parallel words from the PRBS15 generator, or from the serial link after deserialisation. The checker is self-synchronising: it predicts each word from the previously received bits, then reports per-word bit errors, a lock status, and a saturating error count. It is the downstream partner of the PRBS15 generator and uses the same LSB-first bit order and polynomial x^15 + x^14 + 1.

## Interface
- WORDWIDTH, 15: bits per input word. Legal range is 15..64.
- LOCK_COUNT, 4: consecutive clean compared words needed to enter LOCKED. Legal range is 1..255.
- UNLOCK_COUNT, 4: consecutive errored words needed to leave LOCKED. Legal range is 1..255.
- CNTWIDTH, 16: width of the error counter.

Ports:
- clk  input  1  single clock domain, rising edge.
- reset  input  1  asynchronous, active-high.
- dis  input  1  when 1, input is ignored and all state holds (same effect as din_valid=0).
- din_valid  input  1  din carries a word this cycle.
- din  input  WORDWIDTH  received word. Bit 0 is the earliest bit in the stream.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  registered; 1 while the FSM is in LOCKED.
- err_word  output  1  registered one-cycle pulse: the last compared word was errored.
- err_bits  output  7  registered count of mismatching bits in the last compared word.
- err_cnt  output  CNTWIDTH  saturating accumulated bit errors counted while LOCKED.

## Operation
- **Stream model.** Let r[n] be the received bit stream, with din[0] of a word following the most recent bit of the previous word.
  - Predicted bit: p[n] = r[n-14] XOR r[n-15], taken from *received* bits (self-synchronous).
  - hist[14:0] holds the last 15 received bits, with hist[14] the most recent. For each bit j of the current word, the prediction uses hist and din[j-1:0].
- **History load.**
  - The first valid word after reset only loads hist. It sets an internal hist_ok flag and is not compared: err_word=0, err_bits=0.
  - Every later valid word is compared, and then hist is loaded with din[WORDWIDTH-1:WORDWIDTH-15], in all FSM states.
- **Mismatch.** e[j] = din[j] XOR p[j]. err_bits = popcount(e). The word is *errored* if err_bits is not 0.
- **Stuck-zero.** If hist==0 and din==0, the word is errored for FSM purposes with err_bits=0 and err_word=1. This prevents locking onto the all-zero lock-up state.
- **FSM** (2 states, with counters good_cnt and bad_cnt):
  - UNLOCKED:
    - A clean compared word increments good_cnt. When good_cnt reaches LOCK_COUNT, go to LOCKED and clear both counters.
    - An errored word sets good_cnt to 0.
  - LOCKED:
    - An errored word increments bad_cnt. When bad_cnt reaches UNLOCK_COUNT, go to UNLOCKED and clear both counters.
    - A clean word sets bad_cnt to 0.
- **err_cnt.**
  - On each compared word processed while the FSM is in LOCKED (state *before* the update), add err_bits and saturate at all-ones.
  - Words processed in UNLOCKED never add to err_cnt.
  - When clr_err is 1, err_cnt is set to 0 and the cycle's accumulation is discarded (clr_err wins).
- **Error multiplication.** A single flipped line bit yields exactly 3 flagged bits, at offsets 0, +14 and +15, possibly spanning two words. This is expected behaviour, not an implementation choice.

## Timing
- **Reset values:** locked=0, err_word=0, err_bits=0, err_cnt=0, hist=0, hist_ok=0, state=UNLOCKED, good_cnt=0, bad_cnt=0.
- **Latency:** 1 cycle. The outputs for the word sampled at edge k are valid after edge k.
- err_word is 0 in any cycle following an edge with no compared word (din_valid=0 or dis=1). err_bits holds its last value in those cycles.
- locked changes on the same edge that samples the word completing LOCK_COUNT or UNLOCK_COUNT.
- Gaps in din_valid do not break the stream. The next valid word is treated as contiguous with the previous one.
- Reset asserted mid-stream returns everything to reset values immediately. The next valid word is again a history-only word.

## Test plan
- **Clean lock:** generator seeded 15'h1E4C, WORDWIDTH=15, LOCK_COUNT=4, din_valid=1 continuously after reset release. Required: locked rises after the 5th sampling edge (1 history word + 4 clean words); err_cnt stays 0 for 500 words.
- **Single flip:** while locked, invert din[0] of word k. Required: word k gives err_bits=2, word k+1 gives err_bits=1, err_word pulses on both, err_cnt=3, locked stays 1.
- **Loss of lock:** from locked, feed 4 random non-PRBS words. Required: locked falls after the 4th word. Resuming the clean stream re-locks after 4 clean words, and the errors counted while UNLOCKED do not reach err_cnt.
- **Stuck-zero:** after reset, din=0 for 10 words. Required: locked stays 0, err_word=1 for words 2..10, err_bits=0, err_cnt=0.
- **Saturation and clear:** CNTWIDTH=4 while locked, inject 6 single flips (18 errors). Required: err_cnt=15. Asserting clr_err in the same cycle as a 2-bit error word gives err_cnt=0.
- **Gaps and mid-stream reset:**
  - Clean stream with din_valid toggling 1,0,0,1… Required: lock and no errors.
  - Pulse reset while locked. Required: all outputs return to 0 asynchronously, and re-lock takes 5 valid words.
